regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Architectural register file for the single-cycle datapath. Holds 32 x 32-bit registers.
- Sits directly downstream of the 5-bit destination-register mux. That mux's output drives WriteAddr here.
- Provides two combinational read ports for the operand fetch and one synchronous write port for writeback.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored value only

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- ReadAddr1  input  ADDR_W  read port 1 address (rs)
- ReadAddr2  input  ADDR_W  read port 2 address (rt)
- WriteAddr  input  ADDR_W  write address, from destination-register mux
- WriteData  input  DATA_W  writeback data
- WriteEnable  input  1  write strobe, sampled on rising clk
- ReadData1  output  DATA_W  data for ReadAddr1
- ReadData2  output  DATA_W  data for ReadAddr2

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. No asynchronous paths into state.
- Reset:
  - On a rising clk with reset=1, all registers are cleared to 0.
  - Any WriteEnable in that cycle is ignored.
  - While reset=1, ReadData1 and ReadData2 are forced to 0, and bypass is suppressed.
- Reset deasserted mid-stream: the first rising edge with reset=0 and WriteEnable=1 performs a normal write.
- Write:
  - On a rising clk with reset=0, WriteEnable=1 and WriteAddr!=0: reg[WriteAddr] <= WriteData.
  - Writes to address 0 are discarded; reg[0] stays 0 permanently.
  - WriteEnable=0 means no state change.
- Read:
  - Purely combinational, zero latency from address to data.
  - ReadAddrN==0 returns 0 regardless of any write activity.
- Bypass (BYPASS=1):
  - If reset=0, WriteEnable=1, WriteAddr!=0 and WriteAddr==ReadAddrN, then ReadDataN = WriteData in the same cycle, before the edge.
  - Both ports may bypass simultaneously.
- BYPASS=0: ReadDataN shows the stored value. The new value is visible the cycle after the write edge.
- Simultaneous events:
  - Both read ports may address the same register; both return identical data.
  - Read and write to the same address in one cycle follow the bypass rule above.
- Width rules:
  - Addresses are unsigned and always in range; no out-of-range handling is needed.
  - No X is ever driven on the outputs after the first reset.
- Priority order: reset > write-to-zero discard > write > hold.

Decomposition:
- Shared package holds:
  - DATA_W = 32, ADDR_W = 5, NUM_REGS = 32
  - ZERO_REG = 5'd0
  - Named register indices used by control (e.g. RA = 5'd31)
- Read-port logic (zero check, bypass compare, reset gate) is identical for both ports. Implement it as one sub-module, regfile_read_port, instantiated twice.
- The storage array and write logic stay in the top module.

Test Plan:
- Reset clears: write 0xDEADBEEF to r5, assert reset for 1 cycle, read r5 -> ReadData1=0x00000000. While reset=1, both outputs are 0.
- Basic write/read: WriteEnable=1, WriteAddr=7, WriteData=0x12345678 at edge. Next cycle, ReadAddr1=7 -> 0x12345678 and ReadAddr2=7 -> 0x12345678.
- r0 immutable: WriteEnable=1, WriteAddr=0, WriteData=0xFFFFFFFF. Same cycle and next cycle, ReadAddr1=0 -> 0x00000000 with no bypass.
- Bypass with BYPASS=1: r3 holds 0x11111111. Same cycle drive WriteAddr=3, WriteData=0x22222222, WriteEnable=1, ReadAddr2=3 -> ReadData2=0x22222222 before the edge. With BYPASS=0 the result is 0x11111111, then 0x22222222 after the edge.
- WriteEnable low: r9=0xA5A5A5A5, then drive WriteAddr=9, WriteData=0, WriteEnable=0 for 3 cycles -> r9 still reads 0xA5A5A5A5.
- Write during reset: reset=1, WriteEnable=1, WriteAddr=4, WriteData=0xCAFEF00D at edge -> after reset drops, r4 reads 0x00000000.

Source files
------------

// File: rtl/regfile_2r1w_pkg.sv
// Shared constants for the architectural register file.
// Widths, depth and named register indices used by control.
package regfile_2r1w_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_idx_t ZERO_REG = 5'd0;
  localparam reg_idx_t AT       = 5'd1;
  localparam reg_idx_t V0       = 5'd2;
  localparam reg_idx_t V1       = 5'd3;
  localparam reg_idx_t GP       = 5'd28;
  localparam reg_idx_t SP       = 5'd29;
  localparam reg_idx_t FP       = 5'd30;
  localparam reg_idx_t RA       = 5'd31;

  function automatic logic is_zero_reg(
    input reg_idx_t idx
  );
    return idx == ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_2r1w_read_port.sv
// One combinational read port: zero-register, bypass, reset gate.
// Ports: reset, raddr, stored, wen/waddr/wdata in, rdata out.
module regfile_read_port
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W = regfile_2r1w_pkg::DATA_W,
  parameter int ADDR_W = regfile_2r1w_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic raddr_zero;
  logic waddr_zero;
  logic hit;
  logic sel_zero;
  logic sel_byp;
  logic sel_mem;

  assign raddr_zero = (raddr == '0);
  assign waddr_zero = (waddr == '0);

  // Forward only a write that will really land this edge.
  assign hit = BYPASS && wen && !waddr_zero
             && (waddr == raddr);

  // One-hot select so the case below is truly unique.
  assign sel_zero = reset | raddr_zero;
  assign sel_byp  = !sel_zero & hit;
  assign sel_mem  = !sel_zero & !hit;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_zero: rdata = '0;
      sel_byp:  rdata = wdata;
      sel_mem:  rdata = stored;
      default:  rdata = '0;
    endcase
  end

endmodule

// File: rtl/regfile_2r1w.sv
// 32x32 register file, two combinational reads, one sync write.
// Ports: clk, reset, ReadAddr1/2, WriteAddr/Data/Enable, ReadData1/2.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W = regfile_2r1w_pkg::DATA_W,
  parameter int ADDR_W = regfile_2r1w_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              WriteEnable,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int NUM = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NUM];
  logic              wr_go;
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  // Writes to r0 are dropped so r0 never leaves zero.
  assign wr_go = !reset && WriteEnable
              && (WriteAddr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_go) begin
      mem[WriteAddr] <= WriteData;
    end
  end

  assign stored1 = mem[ReadAddr1];
  assign stored2 = mem[ReadAddr2];

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rp1 (
    .reset  (reset),
    .raddr  (ReadAddr1),
    .stored (stored1),
    .wen    (WriteEnable),
    .waddr  (WriteAddr),
    .wdata  (WriteData),
    .rdata  (ReadData1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rp2 (
    .reset  (reset),
    .raddr  (ReadAddr2),
    .stored (stored2),
    .wen    (WriteEnable),
    .waddr  (WriteAddr),
    .wdata  (WriteData),
    .rdata  (ReadData2)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed vector table plus random traffic.
// Drives a BYPASS=1 and a BYPASS=0 instance with the same inputs.
module tb_regfile_2r1w;

  logic        clk;
  logic        reset;
  logic [4:0]  ReadAddr1;
  logic [4:0]  ReadAddr2;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        WriteEnable;
  logic [31:0] rd1_b, rd2_b;
  logic [31:0] rd1_n, rd2_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl [32];

  regfile_2r1w #(.BYPASS(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .ReadAddr1   (ReadAddr1),
    .ReadAddr2   (ReadAddr2),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .WriteEnable (WriteEnable),
    .ReadData1   (rd1_b),
    .ReadData2   (rd2_b)
  );

  regfile_2r1w #(.BYPASS(1'b0)) dut_nb (
    .clk         (clk),
    .reset       (reset),
    .ReadAddr1   (ReadAddr1),
    .ReadAddr2   (ReadAddr2),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .WriteEnable (WriteEnable),
    .ReadData1   (rd1_n),
    .ReadData2   (rd2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] n1;
    logic [31:0] n2;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h",
               name, idx, act, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are read at negedge.
  task automatic drive(input logic r, input logic w,
                       input logic [4:0] wa,
                       input logic [31:0] wd,
                       input logic [4:0] a1,
                       input logic [4:0] a2);
    @(posedge clk);
    #1;
    reset       = r;
    WriteEnable = w;
    WriteAddr   = wa;
    WriteData   = wd;
    ReadAddr1   = a1;
    ReadAddr2   = a2;
    @(negedge clk);
  endtask

  // What the upcoming edge will do to the architectural state.
  task automatic commit();
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
    end else if (WriteEnable && WriteAddr != 0) begin
      mdl[WriteAddr] = WriteData;
    end
  endtask

  function automatic logic [31:0] expect_rd(
    input logic [4:0] a, input bit byp);
    if (reset || a == 0) return '0;
    if (byp && WriteEnable && WriteAddr != 0
        && WriteAddr == a) return WriteData;
    return mdl[a];
  endfunction

  initial begin
    reset       = 1'b1;
    WriteEnable = 1'b0;
    WriteAddr   = '0;
    WriteData   = '0;
    ReadAddr1   = '0;
    ReadAddr2   = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;

    //            rst we wa  wd            ra1 ra2 e1 e2 n1 n2
    vecs.push_back('{1,0,0,  32'h0,        5, 7,
      32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{0,1,5,  32'hDEADBEEF, 5, 0,
      32'hDEADBEEF, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{1,0,0,  32'h0,        5, 5,
      32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{0,0,0,  32'h0,        5, 5,
      32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{0,1,7,  32'h12345678, 7, 7,
      32'h12345678, 32'h12345678, 32'h0, 32'h0});
    vecs.push_back('{0,0,0,  32'h0,        7, 7,
      32'h12345678, 32'h12345678,
      32'h12345678, 32'h12345678});
    vecs.push_back('{0,1,0,  32'hFFFFFFFF, 0, 7,
      32'h0, 32'h12345678, 32'h0, 32'h12345678});
    vecs.push_back('{0,0,0,  32'h0,        0, 0,
      32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{0,1,3,  32'h11111111, 0, 1,
      32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{0,1,3,  32'h22222222, 3, 3,
      32'h22222222, 32'h22222222,
      32'h11111111, 32'h11111111});
    vecs.push_back('{0,0,0,  32'h0,        3, 3,
      32'h22222222, 32'h22222222,
      32'h22222222, 32'h22222222});
    vecs.push_back('{0,1,9,  32'hA5A5A5A5, 9, 3,
      32'hA5A5A5A5, 32'h22222222,
      32'h0, 32'h22222222});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{0,0,9, 32'h0,       9, 9,
        32'hA5A5A5A5, 32'hA5A5A5A5,
        32'hA5A5A5A5, 32'hA5A5A5A5});
    vecs.push_back('{1,1,4,  32'hCAFEF00D, 4, 9,
      32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{0,0,0,  32'h0,        4, 9,
      32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{0,1,4,  32'h0BADF00D, 4, 31,
      32'h0BADF00D, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{0,0,0,  32'h0,        4, 4,
      32'h0BADF00D, 32'h0BADF00D,
      32'h0BADF00D, 32'h0BADF00D});
    vecs.push_back('{0,1,31, 32'h80000001, 31, 4,
      32'h80000001, 32'h0BADF00D,
      32'h0, 32'h0BADF00D});
    vecs.push_back('{0,0,0,  32'h0,        31, 4,
      32'h80000001, 32'h0BADF00D,
      32'h80000001, 32'h0BADF00D});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa,
            vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      check("vec_byp_rd1", i, rd1_b, vecs[i].e1);
      check("vec_byp_rd2", i, rd2_b, vecs[i].e2);
      check("vec_nob_rd1", i, rd1_n, vecs[i].n1);
      check("vec_nob_rd2", i, rd2_n, vecs[i].n2);
      commit();
    end

    for (int c = 0; c < 400; c++) begin
      logic        r, w;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;
      r  = ($urandom_range(0, 40) == 0);
      w  = ($urandom_range(0, 2) != 0);
      wa = ($urandom_range(0, 9) == 0) ? 5'd0
                                       : 5'($urandom);
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
      drive(r, w, wa, wd, a1, a2);
      check("rnd_byp_rd1", c, rd1_b, expect_rd(a1, 1'b1));
      check("rnd_byp_rd2", c, rd2_b, expect_rd(a2, 1'b1));
      check("rnd_nob_rd1", c, rd1_n, expect_rd(a1, 1'b0));
      check("rnd_nob_rd2", c, rd2_n, expect_rd(a2, 1'b0));
      commit();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
